// File: rtl/el2_lsu_dccm_wr_sched.sv
// DCCM write-port scheduler: queued ECC corrections first, then DMA and store-buffer
// commits with a starvation override. Write enable, address and data are registered.
module el2_lsu_dccm_wr_sched #(
    parameter int unsigned DCCM_BITS  = 16,
    parameter int unsigned CQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_tlu_core_ecc_disable,
    input  logic                 corr_valid,
    input  logic [DCCM_BITS-1:0] corr_addr_lo,
    input  logic [DCCM_BITS-1:0] corr_addr_hi,
    input  logic                 corr_dual,
    input  logic [31:0]          corr_data_lo,
    input  logic [31:0]          corr_data_hi,
    input  logic                 dma_req,
    input  logic [DCCM_BITS-1:0] dma_addr,
    input  logic [31:0]          dma_wdata_lo,
    input  logic [31:0]          dma_wdata_hi,
    input  logic                 stbuf_req,
    input  logic [DCCM_BITS-1:0] stbuf_addr,
    input  logic [31:0]          stbuf_wdata,
    input  logic                 dccm_wr_block,
    output logic                 dma_gnt,
    output logic                 stbuf_gnt,
    output logic                 dccm_wen,
    output logic                 dccm_wr_dual,
    output logic [DCCM_BITS-1:0] dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0] dccm_wr_addr_hi,
    output logic [31:0]          dccm_wr_data_lo,
    output logic [31:0]          dccm_wr_data_hi,
    output logic [1:0]           dccm_wr_src,
    output logic                 corr_pending,
    output logic                 corr_drop
);

    localparam int unsigned PW = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(CQ_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CORR  = 2'd1;
    localparam logic [1:0] SRC_DMA   = 2'd2;
    localparam logic [1:0] SRC_STBUF = 2'd3;

    localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
    localparam logic [DCCM_BITS-1:0] HI_OFFSET = DCCM_BITS'(4);

    logic [DCCM_BITS-1:0] cq_addr_lo [CQ_DEPTH];
    logic [DCCM_BITS-1:0] cq_addr_hi [CQ_DEPTH];
    logic                 cq_dual    [CQ_DEPTH];
    logic [31:0]          cq_data_lo [CQ_DEPTH];
    logic [31:0]          cq_data_hi [CQ_DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cq_count, cq_count_d;
    logic [SW-1:0] starve_cnt, starve_cnt_d;

    logic cq_full, cq_empty, corr_push, corr_win, starve_hit, drop_d;

    logic                 wen_d, dual_d;
    logic [1:0]           src_d;
    logic [DCCM_BITS-1:0] addr_lo_d, addr_hi_d;
    logic [31:0]          data_lo_d, data_hi_d;

    assign cq_full    = (cq_count == CW'(CQ_DEPTH));
    assign cq_empty   = (cq_count == '0);
    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

    // Fullness is judged before any same-cycle pop, so a push into a full queue is refused.
    assign corr_push = corr_valid & ~dec_tlu_core_ecc_disable & ~cq_full;
    assign drop_d    = corr_valid & ~dec_tlu_core_ecc_disable & cq_full;

    assign corr_win  = ~dccm_wr_block & ~dec_tlu_core_ecc_disable & ~cq_empty;
    assign stbuf_gnt = ~dccm_wr_block & ~corr_win & stbuf_req & (starve_hit | ~dma_req);
    assign dma_gnt   = ~dccm_wr_block & ~corr_win & dma_req & ~(stbuf_req & starve_hit);

    assign corr_pending = ~cq_empty;

    always_comb begin
        cq_count_d = cq_count;
        unique case ({corr_push, corr_win})
            2'b10:   cq_count_d = cq_count + CW'(1);
            2'b01:   cq_count_d = cq_count - CW'(1);
            default: cq_count_d = cq_count;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt;
        if (!dccm_wr_block) begin
            if (stbuf_gnt || !stbuf_req) begin
                starve_cnt_d = '0;
            end else if (!starve_hit) begin
                starve_cnt_d = starve_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        wen_d     = 1'b0;
        src_d     = SRC_NONE;
        dual_d    = 1'b0;
        addr_lo_d = dccm_wr_addr_lo;
        addr_hi_d = dccm_wr_addr_hi;
        data_lo_d = dccm_wr_data_lo;
        data_hi_d = dccm_wr_data_hi;
        if (corr_win) begin
            wen_d     = 1'b1;
            src_d     = SRC_CORR;
            dual_d    = cq_dual[rd_ptr];
            addr_lo_d = cq_addr_lo[rd_ptr];
            addr_hi_d = cq_addr_hi[rd_ptr];
            data_lo_d = cq_data_lo[rd_ptr];
            data_hi_d = cq_data_hi[rd_ptr];
        end else if (dma_gnt) begin
            wen_d     = 1'b1;
            src_d     = SRC_DMA;
            dual_d    = 1'b1;
            addr_lo_d = dma_addr;
            addr_hi_d = dma_addr + HI_OFFSET;
            data_lo_d = dma_wdata_lo;
            data_hi_d = dma_wdata_hi;
        end else if (stbuf_gnt) begin
            wen_d     = 1'b1;
            src_d     = SRC_STBUF;
            addr_lo_d = stbuf_addr;
            addr_hi_d = stbuf_addr;
            data_lo_d = stbuf_wdata;
            data_hi_d = stbuf_wdata;
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (corr_push) begin
            cq_addr_lo[wr_ptr] <= corr_addr_lo;
            cq_addr_hi[wr_ptr] <= corr_addr_hi;
            cq_dual[wr_ptr]    <= corr_dual;
            cq_data_lo[wr_ptr] <= corr_data_lo;
            cq_data_hi[wr_ptr] <= corr_data_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cq_count <= '0;
        end else if (dec_tlu_core_ecc_disable) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cq_count <= '0;
        end else begin
            if (corr_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (corr_win)  rd_ptr <= rd_ptr + PTR_ONE;
            cq_count <= cq_count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt      <= '0;
            corr_drop       <= 1'b0;
            dccm_wen        <= 1'b0;
            dccm_wr_src     <= SRC_NONE;
            dccm_wr_dual    <= 1'b0;
            dccm_wr_addr_lo <= '0;
            dccm_wr_addr_hi <= '0;
            dccm_wr_data_lo <= '0;
            dccm_wr_data_hi <= '0;
        end else begin
            starve_cnt      <= starve_cnt_d;
            corr_drop       <= drop_d;
            dccm_wen        <= wen_d;
            dccm_wr_src     <= src_d;
            dccm_wr_dual    <= dual_d;
            dccm_wr_addr_lo <= addr_lo_d;
            dccm_wr_addr_hi <= addr_hi_d;
            dccm_wr_data_lo <= data_lo_d;
            dccm_wr_data_hi <= data_hi_d;
        end
    end

endmodule

// File: tb/tb_el2_lsu_dccm_wr_sched.sv
// Directed bench for the DCCM write-port scheduler: priority, starvation, drop,
// ECC-disable flush and asynchronous reset during a drain.
module tb_el2_lsu_dccm_wr_sched;

    logic        clk;
    logic        rst;
    logic        dec_tlu_core_ecc_disable;
    logic        corr_valid;
    logic [15:0] corr_addr_lo, corr_addr_hi;
    logic        corr_dual;
    logic [31:0] corr_data_lo, corr_data_hi;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata_lo, dma_wdata_hi;
    logic        stbuf_req;
    logic [15:0] stbuf_addr;
    logic [31:0] stbuf_wdata;
    logic        dccm_wr_block;
    logic        dma_gnt, stbuf_gnt;
    logic        dccm_wen, dccm_wr_dual;
    logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
    logic [31:0] dccm_wr_data_lo, dccm_wr_data_hi;
    logic [1:0]  dccm_wr_src;
    logic        corr_pending, corr_drop;

    int total = 0;
    int bad = 0;

    el2_lsu_dccm_wr_sched #(
        .DCCM_BITS (16),
        .CQ_DEPTH  (2),
        .STARVE_MAX(7)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dec_tlu_core_ecc_disable(dec_tlu_core_ecc_disable),
        .corr_valid              (corr_valid),
        .corr_addr_lo            (corr_addr_lo),
        .corr_addr_hi            (corr_addr_hi),
        .corr_dual               (corr_dual),
        .corr_data_lo            (corr_data_lo),
        .corr_data_hi            (corr_data_hi),
        .dma_req                 (dma_req),
        .dma_addr                (dma_addr),
        .dma_wdata_lo            (dma_wdata_lo),
        .dma_wdata_hi            (dma_wdata_hi),
        .stbuf_req               (stbuf_req),
        .stbuf_addr              (stbuf_addr),
        .stbuf_wdata             (stbuf_wdata),
        .dccm_wr_block           (dccm_wr_block),
        .dma_gnt                 (dma_gnt),
        .stbuf_gnt               (stbuf_gnt),
        .dccm_wen                (dccm_wen),
        .dccm_wr_dual            (dccm_wr_dual),
        .dccm_wr_addr_lo         (dccm_wr_addr_lo),
        .dccm_wr_addr_hi         (dccm_wr_addr_hi),
        .dccm_wr_data_lo         (dccm_wr_data_lo),
        .dccm_wr_data_hi         (dccm_wr_data_hi),
        .dccm_wr_src             (dccm_wr_src),
        .corr_pending            (corr_pending),
        .corr_drop               (corr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered outputs are stable 1ns after the edge; inputs are driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic queue_corr(input logic [15:0] a, input logic [31:0] d);
        corr_valid   = 1'b1;
        corr_addr_lo = a;
        corr_addr_hi = a + 16'd4;
        corr_dual    = 1'b0;
        corr_data_lo = d;
        corr_data_hi = ~d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_tlu_core_ecc_disable = 1'b0;
        corr_valid = 1'b0; corr_addr_lo = '0; corr_addr_hi = '0; corr_dual = 1'b0;
        corr_data_lo = '0; corr_data_hi = '0;
        dma_req = 1'b0; dma_addr = '0; dma_wdata_lo = '0; dma_wdata_hi = '0;
        stbuf_req = 1'b0; stbuf_addr = '0; stbuf_wdata = '0;
        dccm_wr_block = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({dccm_wen, dccm_wr_src, dccm_wr_dual, corr_pending, corr_drop} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got wen=%b src=%0d dual=%b pend=%b drop=%b want all 0",
                     dccm_wen, dccm_wr_src, dccm_wr_dual, corr_pending, corr_drop);
        end
        total++;
        if ({dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi} !== 96'b0) begin
            bad++;
            $display("FAIL reset_data: got alo=%h ahi=%h dlo=%h dhi=%h want 0",
                     dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi);
        end
        #1;
        total++;
        if ({dma_gnt, stbuf_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt: got dma=%b stbuf=%b want 0 0", dma_gnt, stbuf_gnt);
        end
    endtask

    task automatic test_dma_wrap();
        dma_req = 1'b1; dma_addr = 16'h0FFC;
        dma_wdata_lo = 32'h1111_2222; dma_wdata_hi = 32'h3333_4444;
        #1;
        total++;
        if ({dma_gnt, stbuf_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL dma_gnt: got dma=%b stbuf=%b want 1 0", dma_gnt, stbuf_gnt);
        end
        tick();
        dma_req = 1'b0;
        total++;
        if (dccm_wen !== 1'b1 || dccm_wr_src !== 2'd2 || dccm_wr_dual !== 1'b1) begin
            bad++;
            $display("FAIL dma_write: got wen=%b src=%0d dual=%b want 1 2 1",
                     dccm_wen, dccm_wr_src, dccm_wr_dual);
        end
        total++;
        if (dccm_wr_addr_lo !== 16'h0FFC || dccm_wr_addr_hi !== 16'h1000 ||
            dccm_wr_data_lo !== 32'h1111_2222 || dccm_wr_data_hi !== 32'h3333_4444) begin
            bad++;
            $display("FAIL dma_addr: got %h/%h %h/%h want 0ffc/1000 11112222/33334444",
                     dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi);
        end
        tick();
        total++;
        if (dccm_wen !== 1'b0 || dccm_wr_src !== 2'd0 || dccm_wr_dual !== 1'b0 ||
            dccm_wr_addr_lo !== 16'h0FFC) begin
            bad++;
            $display("FAIL idle_hold: got wen=%b src=%0d dual=%b alo=%h want 0 0 0 0ffc",
                     dccm_wen, dccm_wr_src, dccm_wr_dual, dccm_wr_addr_lo);
        end
    endtask

    task automatic test_corr_priority();
        queue_corr(16'h0100, 32'hDEAD_BEEF);
        tick();
        corr_valid = 1'b0;
        dma_req = 1'b1; dma_addr = 16'h0200;
        dma_wdata_lo = 32'hAAAA_0001; dma_wdata_hi = 32'hAAAA_0002;
        #1;
        total++;
        if (corr_pending !== 1'b1 || dma_gnt !== 1'b0) begin
            bad++;
            $display("FAIL corr_first: got pend=%b dma_gnt=%b want 1 0", corr_pending, dma_gnt);
        end
        tick();
        total++;
        if (dccm_wen !== 1'b1 || dccm_wr_src !== 2'd1 || dccm_wr_data_lo !== 32'hDEAD_BEEF ||
            dccm_wr_addr_lo !== 16'h0100 || dccm_wr_dual !== 1'b0 || corr_pending !== 1'b0) begin
            bad++;
            $display("FAIL corr_write: got wen=%b src=%0d d=%h a=%h dual=%b pend=%b want 1 1 deadbeef 0100 0 0",
                     dccm_wen, dccm_wr_src, dccm_wr_data_lo, dccm_wr_addr_lo, dccm_wr_dual,
                     corr_pending);
        end
        #1;
        total++;
        if (dma_gnt !== 1'b1) begin
            bad++;
            $display("FAIL dma_after_corr: got dma_gnt=%b want 1", dma_gnt);
        end
        tick();
        dma_req = 1'b0;
        total++;
        if (dccm_wr_src !== 2'd2 || dccm_wr_addr_lo !== 16'h0200 || dccm_wr_addr_hi !== 16'h0204) begin
            bad++;
            $display("FAIL dma_follow: got src=%0d alo=%h ahi=%h want 2 0200 0204",
                     dccm_wr_src, dccm_wr_addr_lo, dccm_wr_addr_hi);
        end
        tick();
    endtask

    task automatic test_drop();
        dccm_wr_block = 1'b1;
        queue_corr(16'h0300, 32'h0000_0301);
        tick();
        queue_corr(16'h0310, 32'h0000_0311);
        tick();
        queue_corr(16'h0320, 32'h0000_0321);
        total++;
        if (corr_drop !== 1'b0 || corr_pending !== 1'b1 || dccm_wen !== 1'b0) begin
            bad++;
            $display("FAIL drop_early: got drop=%b pend=%b wen=%b want 0 1 0",
                     corr_drop, corr_pending, dccm_wen);
        end
        tick();
        corr_valid = 1'b0;
        total++;
        if (corr_drop !== 1'b1) begin
            bad++;
            $display("FAIL drop_pulse: got drop=%b want 1", corr_drop);
        end
        tick();
        total++;
        if (corr_drop !== 1'b0 || corr_pending !== 1'b1) begin
            bad++;
            $display("FAIL drop_once: got drop=%b pend=%b want 0 1", corr_drop, corr_pending);
        end
        dccm_wr_block = 1'b0;
        tick();
        total++;
        if (dccm_wen !== 1'b1 || dccm_wr_src !== 2'd1 || dccm_wr_addr_lo !== 16'h0300 ||
            dccm_wr_data_hi !== 32'hFFFF_FCFE || corr_pending !== 1'b1) begin
            bad++;
            $display("FAIL drain_first: got wen=%b src=%0d a=%h dhi=%h pend=%b want 1 1 0300 fffffcfe 1",
                     dccm_wen, dccm_wr_src, dccm_wr_addr_lo, dccm_wr_data_hi, corr_pending);
        end
        tick();
        total++;
        if (dccm_wen !== 1'b1 || dccm_wr_src !== 2'd1 || dccm_wr_addr_lo !== 16'h0310 ||
            corr_pending !== 1'b0) begin
            bad++;
            $display("FAIL drain_second: got wen=%b src=%0d a=%h pend=%b want 1 1 0310 0",
                     dccm_wen, dccm_wr_src, dccm_wr_addr_lo, corr_pending);
        end
        tick();
        total++;
        if (dccm_wen !== 1'b0 || dccm_wr_src !== 2'd0) begin
            bad++;
            $display("FAIL drain_done: got wen=%b src=%0d want 0 0", dccm_wen, dccm_wr_src);
        end
    endtask

    task automatic test_starve();
        int dma_grants;
        dma_grants = 0;
        dma_req = 1'b1; dma_addr = 16'h0400;
        stbuf_req = 1'b1; stbuf_addr = 16'h0500; stbuf_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (dma_gnt === 1'b1 && stbuf_gnt === 1'b0) dma_grants++;
            tick();
        end
        total++;
        if (dma_grants !== 7) begin
            bad++;
            $display("FAIL starve_dma_run: got %0d dma grants want 7", dma_grants);
        end
        #1;
        total++;
        if ({stbuf_gnt, dma_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL starve_override: got stbuf=%b dma=%b want 1 0", stbuf_gnt, dma_gnt);
        end
        tick();
        total++;
        if (dccm_wr_src !== 2'd3 || dccm_wr_dual !== 1'b0 || dccm_wr_addr_lo !== 16'h0500 ||
            dccm_wr_addr_hi !== 16'h0500 || dccm_wr_data_hi !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL stbuf_write: got src=%0d dual=%b a=%h/%h dhi=%h want 3 0 0500/0500 5555aaaa",
                     dccm_wr_src, dccm_wr_dual, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_hi);
        end
        #1;
        total++;
        if ({stbuf_gnt, dma_gnt} !== 2'b01) begin
            bad++;
            $display("FAIL starve_cleared: got stbuf=%b dma=%b want 0 1", stbuf_gnt, dma_gnt);
        end
        dma_req = 1'b0;
        #1;
        total++;
        if (stbuf_gnt !== 1'b1) begin
            bad++;
            $display("FAIL stbuf_alone: got stbuf_gnt=%b want 1", stbuf_gnt);
        end
        tick();
        stbuf_req = 1'b0;
        tick();
    endtask

    task automatic test_ecc_disable();
        dccm_wr_block = 1'b1;
        queue_corr(16'h0600, 32'h0000_0601);
        tick();
        queue_corr(16'h0610, 32'h0000_0611);
        tick();
        corr_valid = 1'b0;
        total++;
        if (corr_pending !== 1'b1) begin
            bad++;
            $display("FAIL dis_queued: got pend=%b want 1", corr_pending);
        end
        dccm_wr_block = 1'b0;
        dec_tlu_core_ecc_disable = 1'b1;
        queue_corr(16'h0620, 32'h0000_0621);
        tick();
        dec_tlu_core_ecc_disable = 1'b0;
        corr_valid = 1'b0;
        total++;
        if (corr_pending !== 1'b0 || corr_drop !== 1'b0 || dccm_wen !== 1'b0) begin
            bad++;
            $display("FAIL dis_flush: got pend=%b drop=%b wen=%b want 0 0 0",
                     corr_pending, corr_drop, dccm_wen);
        end
        tick();
        total++;
        if (dccm_wen !== 1'b0 || dccm_wr_src !== 2'd0 || corr_pending !== 1'b0) begin
            bad++;
            $display("FAIL dis_no_write: got wen=%b src=%0d pend=%b want 0 0 0",
                     dccm_wen, dccm_wr_src, corr_pending);
        end
    endtask

    task automatic test_reset_mid_drain();
        int stale;
        stale = 0;
        dccm_wr_block = 1'b1;
        queue_corr(16'h0700, 32'h0000_0701);
        tick();
        queue_corr(16'h0710, 32'h0000_0711);
        tick();
        corr_valid = 1'b0;
        dccm_wr_block = 1'b0;
        tick();
        total++;
        if (dccm_wen !== 1'b1 || dccm_wr_addr_lo !== 16'h0700 || corr_pending !== 1'b1) begin
            bad++;
            $display("FAIL mid_drain: got wen=%b a=%h pend=%b want 1 0700 1",
                     dccm_wen, dccm_wr_addr_lo, corr_pending);
        end
        rst = 1'b1;
        #1;
        total++;
        if (dccm_wen !== 1'b0 || dccm_wr_src !== 2'd0 || dccm_wr_addr_lo !== 16'h0 ||
            corr_pending !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got wen=%b src=%0d a=%h pend=%b want 0 0 0000 0",
                     dccm_wen, dccm_wr_src, dccm_wr_addr_lo, corr_pending);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dccm_wen !== 1'b0 || corr_pending !== 1'b0) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL no_stale: got %0d cycles with a write or pending entry want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_dma_wrap();
        test_corr_priority();
        test_drop();
        test_starve();
        test_ecc_disable();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
